lsu_ctrl: RTL

//  Load/store sequencer between the bit-sliced datapath and the data-memory port.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_load_align.sv | 37 +++
 rtl/lsu_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-decoding helpers for the load/store sequencer.
package lsu_pkg;

  localparam int XLEN  = 32;
  localparam int NBYTE = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

  // funct3[1:0] carries the access size for every legal encoding (00 byte, 01 half, 10 word).
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic f3_ok;
    logic align_ok;
    if (we) f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~off[0];
      2'b10:   align_ok = (off == 2'b00);
      default: align_ok = 1'b0;
    endcase
    return f3_ok & align_ok;
  endfunction

  function automatic logic [NBYTE-1:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [NBYTE-1:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] lane_replicate(input logic [2:0] f3,
                                                     input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wdata[7:0]}};
      2'b01:   r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request channel (control -> LSU) and data-memory channel (LSU -> dmem) bundles.
interface lsu_req_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready);
endinterface

interface lsu_dmem_if;
  import lsu_pkg::*;

  logic [XLEN-1:0]  dmem_addr;
  logic [NBYTE-1:0] dmem_rmask;
  logic [NBYTE-1:0] dmem_wmask;
  logic [XLEN-1:0]  dmem_wdata;
  logic             dmem_resp;
  logic [XLEN-1:0]  dmem_rdata;

  modport master (output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
                  input  dmem_resp, dmem_rdata);
  modport slave  (input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
                  output dmem_resp, dmem_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half from a dmem read word and produces all five load views.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] lb,
  output logic [XLEN-1:0] lh,
  output logic [XLEN-1:0] lw,
  output logic [XLEN-1:0] lbu,
  output logic [XLEN-1:0] lhu
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Half lane follows addr[1] even for byte loads; the mux picks the view it needs.
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  assign lb  = {{24{byte_sel[7]}}, byte_sel};
  assign lbu = {24'd0, byte_sel};
  assign lh  = {{16{half_sel[15]}}, half_sel};
  assign lhu = {16'd0, half_sel};
  assign lw  = rdata;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one access, drives the word-aligned dmem request,
// waits for the response and registers the aligned load results.
//
//   state | meaning
//   IDLE  | ready for a request; masks off
//   REQ   | dmem request driven, waiting for dmem_resp
//   DONE  | load results valid, commit cycle (no stall)
//   ERR   | misaligned / illegal funct3, one-cycle lsu_err
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  lsu_req_if.slave        req,
  lsu_dmem_if.master      dmem,
  output logic [XLEN-1:0] lb,
  output logic [XLEN-1:0] lh,
  output logic [XLEN-1:0] lw,
  output logic [XLEN-1:0] lbu,
  output logic [XLEN-1:0] lhu,
  output logic            mem_stall,
  output logic            lsu_err
);

  lsu_state_e state_q, state_d;

  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic [XLEN-1:0] lb_q, lb_d;
  logic [XLEN-1:0] lh_q, lh_d;
  logic [XLEN-1:0] lw_q, lw_d;
  logic [XLEN-1:0] lbu_q, lbu_d;
  logic [XLEN-1:0] lhu_q, lhu_d;

  logic            req_legal;
  logic            in_req;
  logic [XLEN-1:0] al_lb, al_lh, al_lw, al_lbu, al_lhu;

  assign req_legal = access_legal(req.req_we, req.req_funct3, req.req_addr[1:0]);
  assign in_req    = (state_q == REQ);

  lsu_load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .offset (addr_q[1:0]),
    .lb     (al_lb),
    .lh     (al_lh),
    .lw     (al_lw),
    .lbu    (al_lbu),
    .lhu    (al_lhu)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req.req_valid) state_d = req_legal ? REQ : ERR;
      REQ:  if (dmem.dmem_resp) state_d = DONE;
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if ((state_q == IDLE) && req.req_valid && req_legal) begin
      we_d    = req.req_we;
      f3_d    = req.req_funct3;
      addr_d  = req.req_addr;
      wdata_d = req.req_wdata;
    end
  end

  // Results update for every completed load regardless of width; stores leave them alone.
  always_comb begin
    lb_d  = lb_q;
    lh_d  = lh_q;
    lw_d  = lw_q;
    lbu_d = lbu_q;
    lhu_d = lhu_q;
    if (in_req && dmem.dmem_resp && !we_q) begin
      lb_d  = al_lb;
      lh_d  = al_lh;
      lw_d  = al_lw;
      lbu_d = al_lbu;
      lhu_d = al_lhu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      lb_q    <= '0;
      lh_q    <= '0;
      lw_q    <= '0;
      lbu_q   <= '0;
      lhu_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lb_q    <= lb_d;
      lh_q    <= lh_d;
      lw_q    <= lw_d;
      lbu_q   <= lbu_d;
      lhu_q   <= lhu_d;
    end
  end

  // dmem drive is decoded from state_q so an async reset drops it without a clock.
  always_comb begin
    dmem.dmem_addr  = '0;
    dmem.dmem_rmask = '0;
    dmem.dmem_wmask = '0;
    dmem.dmem_wdata = '0;
    if (in_req) begin
      dmem.dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
      dmem.dmem_wdata = lane_replicate(f3_q, wdata_q);
      if (we_q) dmem.dmem_wmask = byte_mask(f3_q, addr_q[1:0]);
      else      dmem.dmem_rmask = byte_mask(f3_q, addr_q[1:0]);
    end
  end

  assign req.req_ready = (state_q == IDLE);
  assign mem_stall     = ((state_q == IDLE) && req.req_valid && req_legal) || in_req;
  assign lsu_err       = (state_q == ERR);

  assign lb  = lb_q;
  assign lh  = lh_q;
  assign lw  = lw_q;
  assign lbu = lbu_q;
  assign lhu = lhu_q;

endmodule
